// File: rtl/ysyx_l1i_pkg.sv
// Shared types, geometry and address-split helpers for the ysyx L1 instruction cache.
package ysyx_l1i_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned L1I_LEN      = 4;
  localparam int unsigned L1I_LINE_LEN = 2;

  localparam int unsigned TAG_W = XLEN - L1I_LEN - L1I_LINE_LEN - 2;
  localparam int unsigned LINES = 1 << L1I_LEN;
  localparam int unsigned WORDS = 1 << L1I_LINE_LEN;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFill
  } l1i_state_e;

  function automatic logic [TAG_W-1:0] get_tag(input logic [XLEN-1:0] addr);
    return addr[XLEN-1 -: TAG_W];
  endfunction

  function automatic logic [L1I_LEN-1:0] get_index(input logic [XLEN-1:0] addr);
    return addr[L1I_LEN+L1I_LINE_LEN+1 : L1I_LINE_LEN+2];
  endfunction

  function automatic logic [L1I_LINE_LEN-1:0] get_offset(input logic [XLEN-1:0] addr);
    return addr[L1I_LINE_LEN+1 : 2];
  endfunction

endpackage

// File: rtl/ysyx_l1i_cache.sv
// Direct-mapped read-only L1 I-cache: same-cycle hits, burst line fill on miss, fence.i flush.
// Define YSYX_L1I_CWF_EN to forward the critical word to the IFU during the fill.
module ysyx_l1i_cache
  import ysyx_l1i_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] ifu_pc,
  input  logic            ifu_invalid,
  output logic [31:0]     ifu_inst,
  output logic            ifu_valid,
  output logic            bus_arvalid,
  output logic [XLEN-1:0] bus_araddr,
  input  logic            bus_rready,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_rvalid,
  input  logic            bus_rlast
);

  l1i_state_e              r_state, w_state_next;
  logic [LINES-1:0]        r_valid, w_valid_next;
  logic [TAG_W-1:0]        r_tag  [LINES];
  logic [31:0]             r_data [LINES][WORDS];
  logic [XLEN-1:0]         r_miss_addr, w_miss_addr_next;
  logic [L1I_LINE_LEN-1:0] r_cnt, w_cnt_next;
  logic                    r_flush_pending, w_flush_pending_next;

  logic [TAG_W-1:0]        w_tag;
  logic [L1I_LEN-1:0]      w_index, w_fill_index;
  logic [L1I_LINE_LEN-1:0] w_offset;
  logic                    w_hit, w_miss, w_flush, w_beat, w_line_ok;
  logic                    w_unused_pc;

  assign w_tag        = get_tag(ifu_pc);
  assign w_index      = get_index(ifu_pc);
  assign w_offset     = get_offset(ifu_pc);
  assign w_fill_index = get_index(r_miss_addr);
  assign w_unused_pc  = ^ifu_pc[1:0];

  assign w_hit     = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_miss    = (r_state == StIdle) && !ifu_invalid && !w_hit;
  assign w_flush   = r_flush_pending || ifu_invalid;
  assign w_beat    = (r_state == StFill) && bus_rvalid;
  // Only a full-length burst with no flush in flight may validate the line.
  assign w_line_ok = (r_cnt == L1I_LINE_LEN'(WORDS - 1)) && !w_flush;

  always_comb begin
    w_state_next         = r_state;
    w_valid_next         = r_valid;
    w_miss_addr_next     = r_miss_addr;
    w_cnt_next           = r_cnt;
    w_flush_pending_next = r_flush_pending;
    bus_arvalid          = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (ifu_invalid) begin
          w_valid_next = '0;
        end else if (!w_hit) begin
          w_miss_addr_next      = {w_tag, w_index, {(L1I_LINE_LEN + 2){1'b0}}};
          w_valid_next[w_index] = 1'b0;
          w_state_next          = StReq;
        end
      end
      StReq: begin
        bus_arvalid = 1'b1;
        if (ifu_invalid) w_flush_pending_next = 1'b1;
        if (bus_rready) begin
          w_state_next = StFill;
          w_cnt_next   = '0;
        end
      end
      StFill: begin
        if (ifu_invalid) w_flush_pending_next = 1'b1;
        if (bus_rvalid) begin
          w_cnt_next = r_cnt + 1'b1;
          if (bus_rlast) begin
            w_state_next = StIdle;
            if (w_flush) begin
              w_valid_next         = '0;
              w_flush_pending_next = 1'b0;
            end else if (w_line_ok) begin
              w_valid_next[w_fill_index] = 1'b1;
            end
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign bus_araddr = (r_state == StReq) ? r_miss_addr : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= StIdle;
      r_valid         <= '0;
      r_miss_addr     <= '0;
      r_cnt           <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_valid         <= w_valid_next;
      r_miss_addr     <= w_miss_addr_next;
      r_cnt           <= w_cnt_next;
      r_flush_pending <= w_flush_pending_next;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate every read.
  always_ff @(posedge clock) begin
    if (w_beat) r_data[w_fill_index][r_cnt] <= bus_rdata[31:0];
    if (w_beat && bus_rlast && w_line_ok) r_tag[w_fill_index] <= get_tag(r_miss_addr);
  end

`ifdef YSYX_L1I_CWF_EN
  logic [XLEN-3:0] r_miss_word;
  logic            w_cwf;

  always_ff @(posedge clock) begin
    if (w_miss) r_miss_word <= ifu_pc[XLEN-1:2];
  end

  assign w_cwf = w_beat && !w_flush && (r_cnt == r_miss_word[L1I_LINE_LEN-1:0]) &&
                 (ifu_pc[XLEN-1:2] == r_miss_word);

  always_comb begin
    ifu_valid = ((r_state == StIdle) && w_hit && !ifu_invalid) || w_cwf;
    ifu_inst  = '0;
    if (w_cwf) begin
      ifu_inst = bus_rdata[31:0];
    end else if (ifu_valid) begin
      ifu_inst = r_data[w_index][w_offset];
    end
  end
`else
  logic w_unused_miss;
  assign w_unused_miss = w_miss;

  always_comb begin
    ifu_valid = (r_state == StIdle) && w_hit && !ifu_invalid;
    ifu_inst  = ifu_valid ? r_data[w_index][w_offset] : '0;
  end
`endif

endmodule

// File: tb/tb_ysyx_l1i_cache.sv
// Self-checking bench for ysyx_l1i_cache: hit table, scoreboarded fill addresses, corner sequences.
module tb_ysyx_l1i_cache;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ifu_pc;
  logic        ifu_invalid;
  logic [31:0] ifu_inst;
  logic        ifu_valid;
  logic        bus_arvalid;
  logic [31:0] bus_araddr;
  logic        bus_rready;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        bus_rlast;

`ifdef YSYX_L1I_CWF_EN
  localparam bit CwfEn = 1'b1;
`else
  localparam bit CwfEn = 1'b0;
`endif

  ysyx_l1i_cache u_dut (
    .clock      (clock),
    .reset      (reset),
    .ifu_pc     (ifu_pc),
    .ifu_invalid(ifu_invalid),
    .ifu_inst   (ifu_inst),
    .ifu_valid  (ifu_valid),
    .bus_arvalid(bus_arvalid),
    .bus_araddr (bus_araddr),
    .bus_rready (bus_rready),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .bus_rlast  (bus_rlast)
  );

  always #10 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  typedef struct {
    logic [31:0] pc;
    logic        inv;
    logic        exp_valid;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[9];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0][31:0] mk(input logic [31:0] base);
    logic [3:0][31:0] r;
    for (int i = 0; i < 4; i++) r[i] = base + 32'h11 * 32'(i + 1);
    return r;
  endfunction

  // Fill-address scoreboard: every accepted request must match the next pushed address.
  always @(negedge clock) begin
    if (!reset && bus_arvalid && bus_rready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL araddr: unrequired request %h, queue empty", bus_araddr);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("araddr", bus_araddr, mon_exp);
      end
    end
  end

  task automatic wait_hs(output bit hs);
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clock);
      if (bus_arvalid && bus_rready) hs = 1'b1;
    end
    if (!hs) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_wait: no handshake within 20 cycles, required one");
    end
  endtask

  task automatic do_fill(input logic [3:0][31:0] beats, input int nbeats, input int flush_beat,
                         input logic exp_v_after, input logic [31:0] exp_i_after);
    bit   hs;
    bit   fl;
    logic ev;
    int   cwf_off;
    fl      = 1'b0;
    cwf_off = int'(ifu_pc[3:2]);
    wait_hs(hs);
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clock);
      #1;
      bus_rvalid  = 1'b1;
      bus_rdata   = beats[i];
      bus_rlast   = (i == nbeats - 1);
      ifu_invalid = (i == flush_beat);
      if (i == flush_beat) fl = 1'b1;
      @(negedge clock);
      ev = CwfEn && (i == cwf_off) && !fl;
      chk("fill_valid", 32'(ifu_valid), 32'(ev));
      chk("fill_inst", ifu_inst, ev ? beats[i] : 32'h0);
      chk("fill_arvalid", 32'(bus_arvalid), 32'h0);
    end
    @(posedge clock);
    #1;
    bus_rvalid  = 1'b0;
    bus_rlast   = 1'b0;
    bus_rdata   = '0;
    ifu_invalid = 1'b0;
    @(negedge clock);
    chk("after_valid", 32'(ifu_valid), 32'(exp_v_after));
    chk("after_inst", ifu_inst, exp_v_after ? exp_i_after : 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench still running, required to finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] b;
    bit               hs;
    bit               seen;

    ifu_pc      = 32'h8000_0004;
    ifu_invalid = 1'b0;
    bus_rready  = 1'b1;
    bus_rvalid  = 1'b0;
    bus_rlast   = 1'b0;
    bus_rdata   = '0;

    repeat (2) @(negedge clock);
    chk("rst_valid", 32'(ifu_valid), 32'h0);
    chk("rst_inst", ifu_inst, 32'h0);
    chk("rst_arvalid", 32'(bus_arvalid), 32'h0);
    chk("rst_araddr", bus_araddr, 32'h0);

    // Cold miss.
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.push_back(32'h8000_0000);
    do_fill(mk(32'h0), 4, -1, 1'b1, 32'h22);

    // Combinational lookup table, all applied inside one clock period.
    vecs[0] = '{32'h8000_0000, 1'b0, 1'b1, 32'h11};
    vecs[1] = '{32'h8000_0004, 1'b0, 1'b1, 32'h22};
    vecs[2] = '{32'h8000_0008, 1'b0, 1'b1, 32'h33};
    vecs[3] = '{32'h8000_000C, 1'b0, 1'b1, 32'h44};
    vecs[4] = '{32'h8000_000E, 1'b0, 1'b1, 32'h44};
    vecs[5] = '{32'h8000_0004, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{32'h8000_0010, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{32'h9000_0000, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{32'h8000_0100, 1'b0, 1'b0, 32'h0};
    @(posedge clock);
    #1;
    for (int i = 0; i < 9; i++) begin
      ifu_pc      = vecs[i].pc;
      ifu_invalid = vecs[i].inv;
      #1;
      chk("tbl_valid", 32'(ifu_valid), 32'(vecs[i].exp_valid));
      chk("tbl_inst", ifu_inst, vecs[i].exp_inst);
    end
    ifu_pc      = 32'h8000_000C;
    ifu_invalid = 1'b0;

    // Conflict miss on the same index.
    @(posedge clock);
    #1;
    ifu_pc = 32'h8000_0100;
    exp_q.push_back(32'h8000_0100);
    b = mk(32'hA00);
    do_fill(b, 4, -1, 1'b1, b[0]);

    // Flush during the fill, then the same pc must re-request.
    @(posedge clock);
    #1;
    ifu_pc = 32'h8000_0004;
    exp_q.push_back(32'h8000_0000);
    do_fill(mk(32'hB00), 4, 1, 1'b0, 32'h0);
    exp_q.push_back(32'h8000_0000);
    b = mk(32'hC00);
    do_fill(b, 4, -1, 1'b1, b[1]);

    // Early rlast discards the line.
    @(posedge clock);
    #1;
    ifu_pc = 32'h8000_0010;
    exp_q.push_back(32'h8000_0010);
    do_fill(mk(32'hD00), 3, -1, 1'b0, 32'h0);
    exp_q.push_back(32'h8000_0010);
    b = mk(32'hE00);
    do_fill(b, 4, -1, 1'b1, b[0]);

    // Request stall with stray beats on the bus that must not be consumed.
    @(posedge clock);
    #1;
    bus_rready = 1'b0;
    ifu_pc     = 32'h8000_0024;
    exp_q.push_back(32'h8000_0020);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      if (bus_arvalid) seen = 1'b1;
    end
    if (!seen) chk("stall_req_seen", 32'h0, 32'h1);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEAD_BEEF;
    bus_rlast  = 1'b1;
    for (int s = 0; s < 5; s++) begin
      chk("stall_arvalid", 32'(bus_arvalid), 32'h1);
      chk("stall_araddr", bus_araddr, 32'h8000_0020);
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    bus_rready = 1'b1;
    bus_rvalid = 1'b0;
    bus_rlast  = 1'b0;
    b = mk(32'hF00);
    do_fill(b, 4, -1, 1'b1, b[1]);

    // Flush and miss in the same idle cycle: flush wins, miss follows.
    @(posedge clock);
    #1;
    ifu_pc      = 32'h8000_0008;
    ifu_invalid = 1'b1;
    @(negedge clock);
    chk("flush_valid", 32'(ifu_valid), 32'h0);
    chk("flush_arvalid", 32'(bus_arvalid), 32'h0);
    @(posedge clock);
    #1;
    ifu_invalid = 1'b0;
    exp_q.push_back(32'h8000_0000);
    @(negedge clock);
    chk("postflush_valid", 32'(ifu_valid), 32'h0);
    chk("postflush_arvalid", 32'(bus_arvalid), 32'h0);
    b = mk(32'h1000);
    do_fill(b, 4, -1, 1'b1, b[2]);

    // Reset in the middle of a fill; later beats are ignored.
    @(posedge clock);
    #1;
    ifu_pc = 32'h8000_0044;
    exp_q.push_back(32'h8000_0040);
    wait_hs(hs);
    @(posedge clock);
    #1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1234_5678;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_arvalid", 32'(bus_arvalid), 32'h0);
    chk("midrst_araddr", bus_araddr, 32'h0);
    chk("midrst_valid", 32'(ifu_valid), 32'h0);
    bus_rlast = 1'b1;
    @(posedge clock);
    #1;
    reset       = 1'b0;
    ifu_invalid = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("postrst_arvalid", 32'(bus_arvalid), 32'h0);
      @(posedge clock);
      #1;
    end
    ifu_invalid = 1'b0;
    bus_rvalid  = 1'b0;
    bus_rlast   = 1'b0;
    ifu_pc      = 32'h8000_0008;
    @(negedge clock);
    chk("postrst_valid", 32'(ifu_valid), 32'h0);
    exp_q.push_back(32'h8000_0000);
    b = mk(32'h2000);
    do_fill(b, 4, -1, 1'b1, b[2]);

    repeat (2) @(negedge clock);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_l1i_cache.md
Name: ysyx_l1i_cache

Overview:
- Direct-mapped, read-only L1 instruction cache between the IFU fetch stage and the instruction bus.
- Slave on the IFU side: pc, invalid in; inst, valid out.
- Master on the bus side: burst line fill with arvalid/araddr out; rready/rdata/rvalid/rlast in.
- Hits return in the same cycle. Misses fetch a whole line, and `invalid` (fence.i) flushes every line.

Parameters:
- XLEN, 32, address/data width.
- L1I_LEN, 4, index bits; 2^L1I_LEN lines.
- L1I_LINE_LEN, 2, word-offset bits; 2^L1I_LINE_LEN 32-bit words per line.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ifu_pc  input  XLEN  fetch address, word aligned (bits[1:0] ignored)
- ifu_invalid  input  1  flush-all request (fence.i)
- ifu_inst  output  32  instruction word
- ifu_valid  output  1  ifu_inst valid for current ifu_pc
- bus_arvalid  output  1  line-fill request
- bus_araddr  output  XLEN  line-aligned fill address
- bus_rready  input  1  bus accepts request; handshake = arvalid & rready
- bus_rdata  input  XLEN  fill beat data
- bus_rvalid  input  1  fill beat valid
- bus_rlast  input  1  final beat of fill

Behaviour:
- Address split:
  - offset = pc[L1I_LINE_LEN+1:2]
  - index = pc[L1I_LEN+L1I_LINE_LEN+1:L1I_LINE_LEN+2]
  - tag = remaining upper bits; TAG_W = XLEN-L1I_LEN-L1I_LINE_LEN-2
- Storage: valid bit, tag and data per line, all in flops. The valid array is reset by reset; tag and data are not reset.
- Reset: state=IDLE, all valid bits 0, ifu_valid=0, bus_arvalid=0, bus_araddr=0, ifu_inst=0 whenever ifu_valid=0.
- Hit (combinational): ifu_valid = (state==IDLE) & valid[index] & tag match & !ifu_invalid. ifu_inst = data[index][offset].
- FSM states: IDLE, REQ, FILL.
- IDLE:
  - ifu_invalid: clear all valid bits at the next edge. Stay IDLE, no request.
  - Otherwise, a miss latches miss_addr = {pc tag,index,0..0}, clears valid[index] and goes to REQ.
- REQ:
  - bus_arvalid=1 and bus_araddr=miss_addr, both held stable until the handshake.
  - On arvalid & rready: go to FILL, beat counter=0.
- FILL:
  - Each rvalid beat writes bus_rdata[31:0] to data[index][counter]; the counter increments and wraps modulo 2^L1I_LINE_LEN.
  - On rvalid & rlast: go to IDLE. Set valid[index] and tag only if counter==2^L1I_LINE_LEN-1 and no flush is pending; otherwise the line stays invalid (early rlast = protocol error, line discarded).
- ifu_valid=0 throughout REQ and FILL.
- A pc change during REQ/FILL does not abort the fill. The new pc is looked up in IDLE after completion.
- ifu_invalid in REQ/FILL sets flush_pending:
  - The fill completes but the line is not validated.
  - All valid bits are cleared on the cycle FSM returns to IDLE.
  - flush_pending clears on that cycle.
- ifu_invalid and a miss in the same IDLE cycle: flush wins, no request this cycle; the miss is taken next cycle.
- Latency: hit 0 cycles. Miss = 1 (detect) + request wait + 2^L1I_LINE_LEN beats; hit the cycle after rlast.
- Reset mid-fill: FSM to IDLE, arvalid drops immediately, all lines invalid. Later beats from the bus are ignored while in IDLE.

Optional Feature:
- YSYX_L1I_CWF_EN (critical-word forwarding).
- With it: in FILL, when rvalid and counter == miss offset and ifu_pc == the original miss pc, ifu_valid=1 and ifu_inst=bus_rdata that cycle. Allowed only if no flush is pending.
- Without it: ifu_valid is never asserted outside IDLE.

Decomposition:
- Package ysyx_l1i_pkg holds:
  - state enum (IDLE/REQ/FILL)
  - localparams TAG_W, LINES, WORDS
  - functions to extract tag/index/offset
- No sub-module is natural: the arrays and FSM live inline. Bus fields map one-to-one onto l1i_bus_if master and IFU fields onto ifu_l1i_if slave.

Test Plan:
1. Cold miss: reset, pc=0x8000_0004, bus rready=1, beats 0x11,0x22,0x33,0x44 with rlast on 4th -> araddr=0x8000_0000; ifu_valid=1, inst=0x22 the cycle after rlast.
2. Hit/conflict: after test 1, pc=0x8000_000C -> valid same cycle, inst=0x44. Then pc=0x8000_0100 (same index, different tag) -> miss, araddr=0x8000_0100.
3. Flush during fill: assert ifu_invalid in FILL beat 2 -> fill completes, pc=0x8000_0004 misses again after return to IDLE, new arvalid issued.
4. Early rlast on beat 3 -> line not validated; same pc re-requests.
5. Request stall: rready=0 for 5 cycles -> arvalid/araddr stable all 5 cycles, no beats consumed.
6. CWF_EN: pc=0x8000_0008 miss -> ifu_valid=1 with inst=beat 3 data during beat 3. Without macro -> first valid is the cycle after rlast.
